// File: rtl/eth_tx_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eth_tx_sched_pkg
// Brief   : Shared Ethernet scheduler types, frame-size constants and helpers.
// Rev     : 1.0
// ============================================================================
package eth_tx_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GAP  = 2'd2
  } eth_sched_state_t;

  localparam int ETH_MIN_FRAME = 60;
  localparam int ETH_MAX_FRAME = 1514;

  // Counter/index width that never collapses to zero bits.
  function automatic int idx_width(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/eth_tx_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Brief   : Combinational round-robin pick of the first request after ptr.
// Rev     : 1.0
// ============================================================================
module rr_arbiter
  import eth_tx_sched_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] w_cand;

  // Scan ptr+1 .. ptr+N so the last winner has the lowest priority.
  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = 1'b0;
    w_cand = '0;
    for (int i = 1; i <= N; i++) begin
      w_cand = IDX_W'((int'(ptr) + i) % N);
      if (!valid && req[w_cand]) begin
        valid          = 1'b1;
        idx            = w_cand;
        winner[w_cand] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eth_tx_sched.sv
`default_nettype none
// ============================================================================
// Module  : eth_tx_sched
// Brief   : Round-robin scheduler sharing the Ethernet tx engine between sources.
// Rev     : 1.0
// ============================================================================
module eth_tx_sched
  import eth_tx_sched_pkg::*;
#(
  parameter int NREQ           = 3,
  parameter int LEN_W          = 16,
  parameter int MIN_LEN        = ETH_MIN_FRAME,
  parameter int MAX_LEN        = ETH_MAX_FRAME,
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] req_len,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic [NREQ-1:0]       rejected,
  output logic                  tx_start,
  output logic [LEN_W-1:0]      tx_len,
  input  logic                  tx_done,
  output logic                  err_timeout,
  output logic                  err_clamp,
  output logic [15:0]           frames_sent
);

  localparam int IDX_W = idx_width(NREQ);
  localparam int WD_W  = idx_width(TIMEOUT_CYCLES);
  localparam int GAP_W = idx_width(IFG_CYCLES);

  localparam logic [LEN_W-1:0] c_min_len = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] c_max_len = LEN_W'(MAX_LEN);
  localparam logic [WD_W-1:0]  c_wd_last = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [GAP_W-1:0] c_gap_last = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic             c_has_gap = (IFG_CYCLES != 0);

  eth_sched_state_t r_state, w_state_nxt;

  logic [NREQ-1:0]  r_grant;
  logic [NREQ-1:0]  r_rejected;
  logic             r_tx_start;
  logic [LEN_W-1:0] r_tx_len;
  logic             r_err_clamp;
  logic [15:0]      r_frames;
  logic [IDX_W-1:0] r_ptr;
  logic [WD_W-1:0]  r_wd;
  logic [GAP_W-1:0] r_gap;

  logic [LEN_W-1:0] w_len [NREQ];
  logic [NREQ-1:0]  w_win;
  logic [IDX_W-1:0] w_win_idx;
  logic             w_any;
  logic [LEN_W-1:0] w_win_len;
  logic [LEN_W-1:0] w_adj_len;
  logic             w_clamp;
  logic             w_load;
  logic             w_reject;
  logic             w_finish;
  logic             w_expire;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_len
      assign w_len[gi] = req_len[gi*LEN_W +: LEN_W];
    end
  endgenerate

  rr_arbiter #(
    .N     (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_win),
    .idx    (w_win_idx),
    .valid  (w_any)
  );

  assign w_win_len = w_len[w_win_idx];
  assign w_clamp   = (w_win_len > c_max_len);
  assign w_adj_len = (w_win_len < c_min_len) ? c_min_len :
                     (w_clamp ? c_max_len : w_win_len);

  // tx_done wins over a simultaneous watchdog expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_reject    = 1'b0;
    w_finish    = 1'b0;
    w_expire    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          if (w_win_len == '0) begin
            w_reject = 1'b1;
          end else begin
            w_load      = 1'b1;
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (tx_done) begin
          w_finish    = 1'b1;
          w_state_nxt = c_has_gap ? GAP : IDLE;
        end else if (r_wd == c_wd_last) begin
          w_expire    = 1'b1;
          w_state_nxt = c_has_gap ? GAP : IDLE;
        end
      end
      GAP: begin
        if (r_gap == c_gap_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant     <= '0;
      r_rejected  <= '0;
      r_tx_start  <= 1'b0;
      r_tx_len    <= '0;
      r_err_clamp <= 1'b0;
      r_frames    <= '0;
      r_ptr       <= '0;
      r_wd        <= '0;
      r_gap       <= '0;
    end else begin
      r_tx_start  <= w_load;
      r_err_clamp <= w_load & w_clamp;
      r_rejected  <= w_reject ? w_win : '0;

      if (w_load) begin
        r_grant  <= w_win;
        r_tx_len <= w_adj_len;
      end else if (w_finish || w_expire) begin
        r_grant <= '0;
      end

      if (w_load || w_reject) r_ptr <= w_win_idx;
      if (w_finish)           r_frames <= r_frames + 16'd1;

      if (w_load)                r_wd <= '0;
      else if (r_state == WAIT)  r_wd <= r_wd + 1'b1;

      if (r_state == GAP) r_gap <= r_gap + 1'b1;
      else                r_gap <= '0;
    end
  end

  assign grant       = r_grant;
  assign done        = r_grant & {NREQ{tx_done}};
  assign rejected    = r_rejected;
  assign tx_start    = r_tx_start;
  assign tx_len      = r_tx_len;
  assign err_timeout = w_expire;
  assign err_clamp   = r_err_clamp;
  assign frames_sent = r_frames;

endmodule
`default_nettype wire
